// File: rtl/pic_grey_stream_if.sv
// Video stream and picture-ROM bundle for pic_grey_stream.
// master = timing generator / ROM / encoder side, slave = the converter.
interface pic_grey_stream_if #(
  parameter int ADDR_WIDTH = 16
);
  logic                  vs_in;
  logic                  hs_in;
  logic                  de_in;
  logic                  grey_en;
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [23:0]           rom_rd_data;
  logic                  vs_out;
  logic                  hs_out;
  logic                  de_out;
  logic [23:0]           rgb_out;

  modport master (
    output vs_in, hs_in, de_in, grey_en, rom_rd_data,
    input  rom_addr, vs_out, hs_out, de_out, rgb_out
  );

  modport slave (
    input  vs_in, hs_in, de_in, grey_en, rom_rd_data,
    output rom_addr, vs_out, hs_out, de_out, rgb_out
  );
endinterface

// File: rtl/pic_grey_stream.sv
// Picture window address generator and RGB888-to-luma converter placed between
// the HDMI timing generator and the encoder; sync/DE are delayed 3 cycles to match.
module pic_grey_stream #(
  parameter int          ADDR_WIDTH = 16,
  parameter logic [11:0] PIC_X0     = 12'd512,
  parameter logic [11:0] PIC_Y0     = 12'd232,
  parameter logic [11:0] PIC_W      = 12'd256,
  parameter logic [11:0] PIC_H      = 12'd256,
  parameter logic [23:0] BG_RGB     = 24'h000000
) (
  input  logic               clk,
  input  logic               rst,
  pic_grey_stream_if.slave   bus
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [12:0]           X_END     = {1'b0, PIC_X0} + {1'b0, PIC_W};
  localparam logic [12:0]           Y_END     = {1'b0, PIC_Y0} + {1'b0, PIC_H};

  // Rounded BT.601-style luma; the 17-bit sum never exceeds 65408, so no saturation.
  function automatic logic [7:0] luma8(input logic [23:0] rgb);
    logic [16:0] sum;
    sum = (17'd77  * {9'd0, rgb[23:16]})
        + (17'd150 * {9'd0, rgb[15:8]})
        + (17'd29  * {9'd0, rgb[7:0]})
        + 17'd128;
    return 8'(sum >> 17'd8);
  endfunction

  logic [11:0]           x_cnt_r;
  logic [11:0]           y_cnt_r;
  logic                  vs_prev_r;
  logic                  de_prev_r;
  logic                  frame_valid_r;
  logic                  grey_mode_r;
  logic [ADDR_WIDTH-1:0] addr_cnt_r;
  logic [ADDR_WIDTH-1:0] rom_addr_r;
  logic                  de_d1_r, de_d2_r;
  logic                  hs_d1_r, hs_d2_r;
  logic                  vs_d1_r, vs_d2_r;
  logic                  win_d1_r, win_d2_r;
  logic                  de_out_r, hs_out_r, vs_out_r;
  logic [23:0]           rgb_out_r;

  logic                  vs_rise_s;
  logic                  de_fall_s;
  logic                  in_win_s;
  logic [7:0]            luma_s;
  logic [23:0]           rgb_next_s;

  // Edge detection and window decode for the pixel arriving this cycle.
  always_comb begin
    vs_rise_s = bus.vs_in & ~vs_prev_r;
    de_fall_s = de_prev_r & ~bus.de_in;
    in_win_s  = bus.de_in & frame_valid_r
              & ({1'b0, x_cnt_r} >= {1'b0, PIC_X0}) & ({1'b0, x_cnt_r} < X_END)
              & ({1'b0, y_cnt_r} >= {1'b0, PIC_Y0}) & ({1'b0, y_cnt_r} < Y_END);
  end

  // Position counters, frame qualification, mode latch and ROM addressing.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_cnt_r       <= 12'd0;
      y_cnt_r       <= 12'd0;
      vs_prev_r     <= 1'b0;
      de_prev_r     <= 1'b0;
      frame_valid_r <= 1'b0;
      grey_mode_r   <= 1'b1;
      addr_cnt_r    <= ADDR_ZERO;
      rom_addr_r    <= ADDR_ZERO;
    end else begin
      vs_prev_r <= bus.vs_in;
      de_prev_r <= bus.de_in;
      x_cnt_r   <= bus.de_in ? (x_cnt_r + 12'd1) : 12'd0;
      if (vs_rise_s) begin
        y_cnt_r <= 12'd0;
      end else if (de_fall_s) begin
        y_cnt_r <= y_cnt_r + 12'd1;
      end else begin
        y_cnt_r <= y_cnt_r;
      end
      if (vs_rise_s) begin
        frame_valid_r <= 1'b1;
        grey_mode_r   <= bus.grey_en;
        addr_cnt_r    <= ADDR_ZERO;
        rom_addr_r    <= ADDR_ZERO;
      end else if (in_win_s) begin
        rom_addr_r <= addr_cnt_r;
        addr_cnt_r <= addr_cnt_r + ADDR_ONE;
      end else begin
        rom_addr_r <= rom_addr_r;
        addr_cnt_r <= addr_cnt_r;
      end
    end
  end

  // Output pixel select for the t+3 register; ROM data is valid alongside win_d2.
  always_comb begin
    luma_s     = luma8(bus.rom_rd_data);
    rgb_next_s = 24'h000000;
    if (!de_d2_r) begin
      rgb_next_s = 24'h000000;
    end else if (!win_d2_r) begin
      rgb_next_s = BG_RGB;
    end else if (grey_mode_r) begin
      rgb_next_s = {luma_s, luma_s, luma_s};
    end else begin
      rgb_next_s = bus.rom_rd_data;
    end
  end

  // Sync/DE/window delay line and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      de_d1_r   <= 1'b0;
      de_d2_r   <= 1'b0;
      hs_d1_r   <= 1'b0;
      hs_d2_r   <= 1'b0;
      vs_d1_r   <= 1'b0;
      vs_d2_r   <= 1'b0;
      win_d1_r  <= 1'b0;
      win_d2_r  <= 1'b0;
      de_out_r  <= 1'b0;
      hs_out_r  <= 1'b0;
      vs_out_r  <= 1'b0;
      rgb_out_r <= 24'h000000;
    end else begin
      de_d1_r   <= bus.de_in;
      de_d2_r   <= de_d1_r;
      hs_d1_r   <= bus.hs_in;
      hs_d2_r   <= hs_d1_r;
      vs_d1_r   <= bus.vs_in;
      vs_d2_r   <= vs_d1_r;
      win_d1_r  <= in_win_s;
      win_d2_r  <= win_d1_r;
      de_out_r  <= de_d2_r;
      hs_out_r  <= hs_d2_r;
      vs_out_r  <= vs_d2_r;
      rgb_out_r <= rgb_next_s;
    end
  end

  assign bus.rom_addr = rom_addr_r;
  assign bus.de_out   = de_out_r;
  assign bus.hs_out   = hs_out_r;
  assign bus.vs_out   = vs_out_r;
  assign bus.rgb_out  = rgb_out_r;

endmodule

// File: tb/tb_pic_grey_stream.sv
// Scoreboard bench for pic_grey_stream on a reduced raster (12x8 active, 4x4 window,
// 16-entry ROM) so every window boundary and the address wrap are hit each frame.
module tb_pic_grey_stream;

  localparam int          AW    = 4;
  localparam int          X0    = 5;
  localparam int          Y0    = 2;
  localparam int          W     = 4;
  localparam int          H     = 4;
  localparam logic [23:0] BG    = 24'h123456;
  localparam int          ACT_W = 12;
  localparam int          TOT_W = 16;
  localparam int          ACT_H = 8;
  localparam int          VBL   = 3;

  typedef struct {
    logic          vs;
    logic          hs;
    logic          de;
    logic [23:0]   rgb;
    logic          chk_addr;
    logic [AW-1:0] addr;
  } exp_t;

  typedef struct {
    logic [23:0] rgb;
    logic        grey;
    logic [7:0]  y;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  pic_grey_stream_if #(.ADDR_WIDTH(AW)) bus();

  pic_grey_stream #(
    .ADDR_WIDTH(AW), .PIC_X0(12'(X0)), .PIC_Y0(12'(Y0)),
    .PIC_W(12'(W)), .PIC_H(12'(H)), .BG_RGB(BG)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // ROM model: registered read, 1-cycle latency
  logic        rom_const_mode = 1'b0;
  logic [23:0] rom_const      = 24'h000000;
  logic [7:0]  cur_luma       = 8'd0;
  always @(posedge clk)
    bus.rom_rd_data <= rom_const_mode ? rom_const : 24'(bus.rom_addr);

  exp_t exp_q[$];
  vec_t vt[7];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   first_de = -1;
  int   first_deo = -1;
  bit   fv_m = 1'b0;
  bit   grey_m = 1'b1;

  function automatic logic [7:0] luma_ref(input logic [23:0] p);
    int s;
    s = 77 * int'(p[23:16]) + 150 * int'(p[15:8]) + 29 * int'(p[7:0]) + 128;
    return 8'(s / 256);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    repeat (2) begin
      @(posedge clk); #1; cyc++;
      check("rst_rgb_out", 32'(bus.rgb_out), 32'd0);
      check("rst_de_out", 32'(bus.de_out), 32'd0);
      check("rst_hs_out", 32'(bus.hs_out), 32'd0);
      check("rst_vs_out", 32'(bus.vs_out), 32'd0);
      check("rst_rom_addr", 32'(bus.rom_addr), 32'd0);
    end
    rst    = 1'b0;
    fv_m   = 1'b0;
    grey_m = 1'b1;
  endtask

  task automatic drive_cycle(input logic vs, input logic hs, input logic de, input logic win,
                             input logic [23:0] wv, input logic [AW-1:0] addr);
    exp_t r;
    bus.vs_in  = vs;
    bus.hs_in  = hs;
    bus.de_in  = de;
    r.vs       = vs;
    r.hs       = hs;
    r.de       = de;
    r.rgb      = !de ? 24'h000000 : (win ? wv : BG);
    r.chk_addr = win;
    r.addr     = addr;
    exp_q.push_back(r);
    if (de && first_de < 0) first_de = cyc;
    @(posedge clk); #1; cyc++;
    if (bus.de_out && first_deo < 0) first_deo = cyc;
    if (r.chk_addr) check("rom_addr", 32'(bus.rom_addr), 32'(addr));
    if (exp_q.size() == 3) begin
      r = exp_q.pop_front();
      check("rgb_out", 32'(bus.rgb_out), 32'(r.rgb));
      check("de_out", 32'(bus.de_out), 32'(r.de));
      check("hs_out", 32'(bus.hs_out), 32'(r.hs));
      check("vs_out", 32'(bus.vs_out), 32'(r.vs));
    end
  endtask

  // One frame; vs on lines 0-1, optional reset and grey_en toggle at given points.
  task automatic run_frame(input bit with_vs, input int rst_line, input int rst_col,
                           input int tog_line, input logic tog_val);
    for (int l = 0; l < VBL + ACT_H; l++) begin
      for (int c = 0; c < TOT_W; c++) begin
        logic        vs, hs, de, win;
        int          y, a;
        logic [23:0] a24, wv;
        if (l == rst_line && c == rst_col) do_reset();
        if (c == 0 && l == tog_line) bus.grey_en = tog_val;
        vs = with_vs && (l < 2);
        if (vs && l == 0 && c == 0) begin
          fv_m   = 1'b1;
          grey_m = bus.grey_en;
        end
        de  = (l >= VBL) && (c < ACT_W);
        hs  = (c >= ACT_W + 1) && (c < ACT_W + 3);
        y   = l - VBL;
        win = fv_m && de && (c >= X0) && (c < X0 + W) && (y >= Y0) && (y < Y0 + H);
        a   = win ? ((y - Y0) * W + (c - X0)) : 0;
        a24 = 24'(a);
        if (rom_const_mode) wv = grey_m ? {3{cur_luma}} : rom_const;
        else                wv = grey_m ? {3{luma_ref(a24)}} : a24;
        drive_cycle(vs, hs, de, win, wv, AW'(a));
      end
    end
  endtask

  initial begin
    vt[0] = '{rgb: 24'hFF0000, grey: 1'b1, y: 8'd77};
    vt[1] = '{rgb: 24'hFFFFFF, grey: 1'b1, y: 8'd255};
    vt[2] = '{rgb: 24'h000000, grey: 1'b1, y: 8'd0};
    vt[3] = '{rgb: 24'h00FF00, grey: 1'b1, y: 8'd149};
    vt[4] = '{rgb: 24'h0000FF, grey: 1'b1, y: 8'd29};
    vt[5] = '{rgb: 24'h808080, grey: 1'b1, y: 8'd128};
    vt[6] = '{rgb: 24'h123456, grey: 1'b0, y: 8'd0};

    bus.vs_in   = 1'b0;
    bus.hs_in   = 1'b0;
    bus.de_in   = 1'b0;
    bus.grey_en = 1'b1;
    do_reset();

    // Active lines before any vs: background only, DE latency measured.
    run_frame(1'b0, -1, -1, -1, 1'b0);
    check("de_latency", 32'(first_deo - first_de), 32'd3);

    // ROM data = address: grey, then passthrough; addresses restart each frame.
    run_frame(1'b1, -1, -1, -1, 1'b0);
    bus.grey_en = 1'b0;
    run_frame(1'b1, -1, -1, -1, 1'b0);

    // Constant ROM colours through the luma path and passthrough.
    rom_const_mode = 1'b1;
    for (int i = 0; i < 7; i++) begin
      rom_const   = vt[i].rgb;
      cur_luma    = vt[i].y;
      bus.grey_en = vt[i].grey;
      run_frame(1'b1, -1, -1, -1, 1'b0);
    end

    // Mode toggle mid-window takes effect only from the next frame.
    rom_const   = 24'hFF0000;
    cur_luma    = 8'd77;
    bus.grey_en = 1'b1;
    run_frame(1'b1, -1, -1, VBL + 3, 1'b0);
    run_frame(1'b1, -1, -1, -1, 1'b0);

    // Reset mid-line inside the window, then a clean frame from address 0.
    rom_const_mode = 1'b0;
    run_frame(1'b1, VBL + 3, 6, -1, 1'b0);
    run_frame(1'b1, -1, -1, -1, 1'b0);

    repeat (4) drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 24'h000000, AW'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
